sig_gen_pn: RTL

Parametrised successor to the 16-lane two-phase generator. Emits LANES output samples per p_clock for CHANNELS phase-locked square-wave channels that share one period counter. Channel 0 is the phase reference. Channels 1..CHANNELS-1 each carry an independently programmable phase offset. Period and phase updates are shadowed and applied atomically at period rollover. Sits between the control-register block and the lane serialiser or gate-drive outputs.

---
 rtl/sig_gen_pn.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sig_gen_pn.sv
// sig_gen_pn: CHANNELS phase-locked square-wave generators that share one
// period counter, each emitting LANES samples per p_clock frame.
// Channel 0 is the phase reference. Channels 1..CHANNELS-1 carry a programmable
// phase offset. Period and phase writes are shadowed and take effect together
// at the next period rollover. They take effect at once while enable is low.
// Optional build macro SIG_GEN_PN_DUTY_EN adds duty_in/set_duty, a shadowed
// duty fraction shared by all channels. Without it the duty is fixed at 50 %.
module sig_gen_pn #(
  parameter int LANES          = 16,
  parameter int CHANNELS       = 2,
  parameter int COUNT_WIDTH    = 32,
  parameter int PHASE_BITS     = 10,
  parameter int INITIAL_PERIOD = 1600
) (
  input  logic                          p_clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [COUNT_WIDTH-1:0]        period_in,
  input  logic                          set_period,
  input  logic [PHASE_BITS-1:0]         phase_in,
  input  logic [$clog2(CHANNELS):0]     phase_sel,
  input  logic                          set_phase,
`ifdef SIG_GEN_PN_DUTY_EN
  input  logic [PHASE_BITS-1:0]         duty_in,
  input  logic                          set_duty,
`endif
  output logic [CHANNELS*LANES-1:0]     p_out,
  output logic                          frame_sync,
  output logic                          update_pending
);

  localparam int CW = COUNT_WIDTH;
  localparam int PW = COUNT_WIDTH + PHASE_BITS;
  // The shortest legal period is two frames. This guarantees at most one wrap per frame.
  localparam logic [CW-1:0] MIN_PERIOD   = CW'(2 * LANES);
  localparam logic [CW-1:0] RESET_PERIOD =
    (INITIAL_PERIOD < 2 * LANES) ? MIN_PERIOD : CW'(INITIAL_PERIOD);

  function automatic logic [CW-1:0] clamp_period(input logic [CW-1:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  // One channel's frame. Each addition stays below two periods, so a single
  // conditional subtract per stage replaces a modulo.
  function automatic logic [LANES-1:0] chan_frame(input logic [CW-1:0] cnt,
                                                  input logic [CW-1:0] off,
                                                  input logic [CW-1:0] per,
                                                  input logic [CW-1:0] ht);
    logic [CW:0]      base;
    logic [CW:0]      pos;
    logic [LANES-1:0] f;
    base = {1'b0, cnt} + {1'b0, off};
    if (base >= {1'b0, per}) base = base - {1'b0, per};
    for (int i = 0; i < LANES; i++) begin
      pos = base + (CW+1)'(i);
      if (pos >= {1'b0, per}) pos = pos - {1'b0, per};
      f[i] = (pos < {1'b0, ht});
    end
    return f;
  endfunction

  logic [CW-1:0]                        counter;
  logic [CW-1:0]                        period;
  logic [CW-1:0]                        period_shadow;
  logic                                 period_pend;
  logic [CHANNELS-1:0][PHASE_BITS-1:0]  phase;
  logic [CHANNELS-1:0][PHASE_BITS-1:0]  phase_shadow;
  logic [CHANNELS-1:0]                  phase_pend;

  logic [CW:0]                          frame_end;
  logic                                 rollover;
  logic                                 sync_now;
  logic                                 apply;
  logic [CW-1:0]                        counter_next;
  logic [CW-1:0]                        high_time;
  logic [CHANNELS-1:0][CW-1:0]          offset;
  logic [CHANNELS*LANES-1:0]            frame;

  assign frame_end    = {1'b0, counter} + (CW+1)'(LANES);
  assign rollover     = (frame_end >= {1'b0, period});
  assign counter_next = rollover ? CW'(frame_end - {1'b0, period}) : CW'(frame_end);
  assign sync_now     = (counter == '0) || (frame_end > {1'b0, period});
  // Shadows go live at a rollover, and on every cycle while the generator is idle.
  assign apply        = !enable || rollover;

`ifdef SIG_GEN_PN_DUTY_EN
  localparam logic [PHASE_BITS-1:0] HALF_DUTY = {1'b1, {(PHASE_BITS-1){1'b0}}};
  logic [PHASE_BITS-1:0] duty;
  logic [PHASE_BITS-1:0] duty_shadow;
  logic                  duty_pend;
  logic [PW-1:0]         duty_prod;

  assign duty_prod = PW'(duty) * PW'(period);
  assign high_time = ((duty_prod >> PHASE_BITS) >= PW'(period)) ? period
                                                                : CW'(duty_prod >> PHASE_BITS);

  // Duty shadow: loaded by set_duty and applied with the period and phase shadows.
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      duty        <= HALF_DUTY;
      duty_shadow <= '0;
      duty_pend   <= 1'b0;
    end else begin
      if (apply) begin
        if (duty_pend) duty <= duty_shadow;
        duty_pend <= 1'b0;
      end
      if (set_duty) begin
        duty_shadow <= duty_in;
        duty_pend   <= 1'b1;
      end
    end
  end

  assign update_pending = period_pend | (|phase_pend) | duty_pend;
`else
  assign high_time      = period >> 1;
  assign update_pending = period_pend | (|phase_pend);
`endif

  // Offset per channel: a full-width product, so it is always less than one period.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    offset = '0;
    for (int c = 0; c < CHANNELS; c++)
      offset[c] = CW'((PW'(phase[c]) * PW'(period)) >> PHASE_BITS);
  end

  // Sample pattern for the frame that the current counter value describes.
  always_comb begin
    frame = '0;
    for (int c = 0; c < CHANNELS; c++)
      frame[c*LANES +: LANES] = chan_frame(counter, offset[c], period, high_time);
  end

  // Period/phase shadows. A strobe in the same cycle as apply re-arms its pending bit.
  // The new value therefore waits for the following rollover.
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: shadows and their pending bits are reset explicitly so a write
      // that was in flight before reset can never be applied after it.
      period        <= RESET_PERIOD;
      period_shadow <= '0;
      period_pend   <= 1'b0;
      phase         <= '0;
      phase_shadow  <= '0;
      phase_pend    <= '0;
    end else begin
      if (apply) begin
        if (period_pend) period <= clamp_period(period_shadow);
        for (int c = 0; c < CHANNELS; c++)
          if (phase_pend[c]) phase[c] <= phase_shadow[c];
        period_pend <= 1'b0;
        phase_pend  <= '0;
      end
      if (set_period) begin
        period_shadow <= period_in;
        period_pend   <= 1'b1;
      end
      // Channel 0 is the reference. A zero or out-of-range phase_sel matches no channel.
      for (int c = 1; c < CHANNELS; c++) begin
        if (set_phase && (int'(phase_sel) == c)) begin
          phase_shadow[c] <= phase_in;
          phase_pend[c]   <= 1'b1;
        end
      end
    end
  end

  // Counter and registered outputs. The outputs show the previous cycle's frame.
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of block ordering.
      counter    <= '0;
      p_out      <= '0;
      frame_sync <= 1'b0;
    end else if (!enable) begin
      counter    <= '0;
      p_out      <= '0;
      frame_sync <= 1'b0;
    end else begin
      counter    <= counter_next;
      p_out      <= frame;
      frame_sync <= sync_now;
    end
  end

endmodule
